serial_comm_pkt: RTL and testbench

- Parametrised full-duplex serial command/response port with built-in 8N1 UART transmit and receive. No external byte transceiver.
- Receives CMD_BYTES-byte commands, most significant byte first, and presents them as one word.
- Transmits RESP_BYTES-byte responses, most significant byte first, on a single trmt pulse.
- Sits between the host RX/TX pins and the command processor. Adds inter-byte timeout resync, framing-error reporting, busy/done handshake and optional checksum.

---
 rtl/serial_comm_pkt.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_serial_comm_pkt.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comm_pkt.sv
// serial_comm_pkt
// Full-duplex 8N1 serial command/response port. Received bytes (MSB byte
// first) are assembled into a CMD_BYTES-wide command word; a trmt pulse sends
// a RESP_BYTES-wide response word, MSB byte first, each byte LSB first.
// A partial command is dropped after TIMEOUT_BITS idle bit-times.
//
// Optional feature: define SERIAL_COMM_PKT_CHECKSUM_EN to append/verify a
// checksum byte (bitwise NOT of the mod-256 payload sum) in both directions.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   RX       asynchronous serial input, idle high
//   TX       registered serial output, idle high
//   cmd      last complete command, first received byte in the MSBs
//   cmd_rdy  one-cycle pulse when cmd updates
//   cmd_err  one-cycle pulse on checksum mismatch (0 without the feature)
//   frm_err  one-cycle pulse when a stop bit is sampled low
//   tx_data  response word, MSB byte sent first
//   trmt     one-cycle pulse starting a response (accepted only when idle)
//   tx_busy  high while a response is being sent
//   tx_done  one-cycle pulse when the response completes
module serial_comm_pkt #(
  parameter int CMD_BYTES    = 3,
  parameter int RESP_BYTES   = 2,
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RX,
  output logic                    TX,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  output logic                    cmd_err,
  output logic                    frm_err,
  input  logic [8*RESP_BYTES-1:0] tx_data,
  input  logic                    trmt,
  output logic                    tx_busy,
  output logic                    tx_done
);

`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
  localparam int CS_BYTES = 1;
`else
  localparam int CS_BYTES = 0;
`endif

  localparam int RX_TOTAL = CMD_BYTES + CS_BYTES;
  localparam int TX_TOTAL = RESP_BYTES + CS_BYTES;
  localparam int BCW      = $clog2(BAUD_DIV);
  localparam int RBW      = $clog2(RX_TOTAL + 1);
  localparam int TBW      = $clog2(TX_TOTAL + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TOW      = $clog2(TO_LIMIT + 1);

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_DIV / 2 - 1);
  localparam logic [RBW-1:0] RX_LAST   = RBW'(RX_TOTAL - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TO_LIMIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t              rx_state, rx_next;
  logic                   rx_meta, rx_sync, rx_prev;
  logic                   rx_fall, rx_tick, stop_tick, byte_ok, byte_bad;
  logic [BCW-1:0]         rx_cnt;
  logic [2:0]             rx_bit;
  logic [7:0]             rx_shift;
  logic [RBW-1:0]         rx_bytes;
  logic [TOW-1:0]         to_cnt;
  logic [8*CMD_BYTES-1:0] asm_reg;
  logic [8*CMD_BYTES+7:0] asm_wide;

  // Synchronizer flops preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall   = rx_prev & ~rx_sync;
  assign rx_tick   = ((rx_state == RX_START) && (rx_cnt == BAUD_HALF)) ||
                     ((rx_state == RX_DATA || rx_state == RX_STOP) && (rx_cnt == BAUD_LAST));
  assign stop_tick = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST);
  assign byte_ok   = stop_tick & rx_sync;
  assign byte_bad  = stop_tick & ~rx_sync;
  // Concatenate then truncate so a single-byte command needs no special case.
  assign asm_wide  = {asm_reg, rx_shift};

  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timing: the counter restarts at every sample point so later samples
  // land BAUD_DIV apart, centred on each bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + BCW'(1);
      if (rx_state == RX_START)           rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_tick) rx_bit <= rx_bit + 3'd1;
      if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
  logic [7:0] rx_sum;
  logic       cmd_err_q;
  assign cmd_err = cmd_err_q;
`else
  assign cmd_err = 1'b0;
`endif

  // Command assembly, completion and inter-byte timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_bytes  <= '0;
      asm_reg   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frm_err   <= 1'b0;
      to_cnt    <= '0;
`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
      rx_sum    <= '0;
      cmd_err_q <= 1'b0;
`endif
    end else begin
      cmd_rdy <= 1'b0;
      frm_err <= 1'b0;
`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
      cmd_err_q <= 1'b0;
`endif
      if (byte_bad) begin
        frm_err  <= 1'b1;
        rx_bytes <= '0;
      end else if (byte_ok) begin
        if (rx_bytes == RX_LAST) begin
          rx_bytes <= '0;
`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
          if (rx_shift == ~rx_sum) begin
            cmd     <= asm_reg;
            cmd_rdy <= 1'b1;
          end else begin
            cmd_err_q <= 1'b1;
          end
`else
          cmd     <= asm_wide[8*CMD_BYTES-1:0];
          cmd_rdy <= 1'b1;
`endif
        end else begin
          rx_bytes <= rx_bytes + RBW'(1);
          asm_reg  <= asm_wide[8*CMD_BYTES-1:0];
`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
          // The first byte of a command restarts the running sum.
          rx_sum   <= (rx_bytes == '0) ? rx_shift : rx_sum + rx_shift;
`endif
        end
      end else if (to_cnt == TO_LAST) begin
        rx_bytes <= '0;
      end
      // Only idle time inside a partial command counts toward the timeout.
      if (rx_state != RX_IDLE || rx_bytes == '0 || to_cnt == TO_LAST) to_cnt <= '0;
      else                                                            to_cnt <= to_cnt + TOW'(1);
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t              tx_state, tx_next;
  logic [BCW-1:0]         tx_cnt;
  logic [2:0]             tx_bit;
  logic [TBW-1:0]         tx_bytes;
  logic [8*TX_TOTAL-1:0]  tx_buf, tx_load;
  logic [7:0]             tx_cur;
  logic                   tx_tick;

`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
  logic [7:0] tx_sum;
  always_comb begin
    tx_sum = '0;
    for (int i = 0; i < RESP_BYTES; i++) tx_sum = tx_sum + tx_data[8*i +: 8];
  end
  assign tx_load = {tx_data, ~tx_sum};
`else
  assign tx_load = tx_data;
`endif

  assign tx_cur  = tx_buf[8*TX_TOTAL-1 -: 8];
  assign tx_tick = (tx_state != TX_IDLE) && (tx_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (trmt) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = (tx_bytes == TBW'(1)) ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX is registered and always carries the level of the state being entered,
  // so bytes chain back-to-back and the line is high whenever the FSM idles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_bytes <= '0;
      tx_buf   <= '0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + BCW'(1);
      case (tx_state)
        TX_IDLE: begin
          TX <= 1'b1;
          if (trmt) begin
            tx_buf   <= tx_load;
            tx_bytes <= TBW'(TX_TOTAL);
            tx_busy  <= 1'b1;
            TX       <= 1'b0;
          end
        end
        TX_START: if (tx_tick) begin
          TX     <= tx_cur[0];
          tx_bit <= '0;
        end
        TX_DATA: if (tx_tick) begin
          TX     <= (tx_bit == 3'd7) ? 1'b1 : tx_cur[tx_bit + 3'd1];
          tx_bit <= tx_bit + 3'd1;
        end
        TX_STOP: if (tx_tick) begin
          if (tx_bytes == TBW'(1)) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            TX      <= 1'b1;
          end else begin
            tx_bytes <= tx_bytes - TBW'(1);
            tx_buf   <= tx_buf << 8;
            TX       <= 1'b0;
          end
        end
        default: TX <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comm_pkt.sv
// tb_serial_comm_pkt
// Directed self-checking bench for serial_comm_pkt with BAUD_DIV=8 and
// TIMEOUT_BITS=20. Serial frames are driven and sampled on the falling clock
// edge; pulse outputs are counted by a falling-edge monitor.
module tb_serial_comm_pkt;

  localparam int CMD_BYTES    = 3;
  localparam int RESP_BYTES   = 2;
  localparam int BAUD_DIV     = 8;
  localparam int TIMEOUT_BITS = 20;
`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy, cmd_err, frm_err;
  logic [15:0] tx_data;
  logic        trmt;
  logic        tx_busy, tx_done;

  int checks = 0;
  int errors = 0;
  int rdy_count = 0, frm_count = 0, cerr_count = 0, done_count = 0, busy_cycles = 0;

  serial_comm_pkt #(
    .CMD_BYTES(CMD_BYTES), .RESP_BYTES(RESP_BYTES),
    .BAUD_DIV(BAUD_DIV), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .cmd_err(cmd_err), .frm_err(frm_err),
    .tx_data(tx_data), .trmt(trmt), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Pulse and busy-duration bookkeeping, sampled away from the active edge.
  always @(negedge clk) begin
    if (cmd_rdy) rdy_count++;
    if (frm_err) frm_count++;
    if (cmd_err) cerr_count++;
    if (tx_done) done_count++;
    if (tx_busy) busy_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One 8N1 frame on RX, LSB first, with a selectable stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    RX = stop;
    repeat (BAUD_DIV) @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Sends one response and decodes TX at mid-bit; optionally pulses trmt with
  // different data while the first byte is in flight.
  task automatic applyTx(input logic [15:0] data, input bit poke);
    logic [7:0] exp_b [3];
    logic [9:0] frame;
    int bbase, dbase;
    exp_b[0] = data[15:8];
    exp_b[1] = data[7:0];
    exp_b[2] = ~(data[15:8] + data[7:0]);
    bbase = busy_cycles;
    dbase = done_count;
    @(negedge clk);
    tx_data = data;
    trmt    = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    repeat (BAUD_DIV / 2) @(negedge clk);
    for (int b = 0; b < RESP_BYTES + CS; b++) begin
      for (int k = 0; k < 10; k++) begin
        frame[k] = TX;
        if (poke && b == 0 && k == 5) begin
          tx_data = 16'h1234;
          trmt    = 1'b1;
          @(negedge clk);
          trmt = 1'b0;
          repeat (BAUD_DIV - 1) @(negedge clk);
        end else begin
          repeat (BAUD_DIV) @(negedge clk);
        end
      end
      checkOutput("tx_start_bit", {31'd0, frame[0]}, 32'd0);
      checkOutput("tx_byte", {24'd0, frame[8:1]}, {24'd0, exp_b[b]});
      checkOutput("tx_stop_bit", {31'd0, frame[9]}, 32'd1);
    end
    repeat (4) @(negedge clk);
    checkOutput("tx_busy_cycles", busy_cycles - bbase, 10 * BAUD_DIV * (RESP_BYTES + CS));
    checkOutput("tx_done_pulses", done_count - dbase, 1);
    checkOutput("tx_idle_level", {31'd0, TX}, 32'd1);
    checkOutput("tx_busy_after", {31'd0, tx_busy}, 32'd0);
  endtask

  // Sends a 3-byte command, plus its checksum when the feature is built in.
  task automatic send_cmd(input logic [23:0] c);
    applyStimulus(c[23:16], 1'b1);
    applyStimulus(c[15:8], 1'b1);
    applyStimulus(c[7:0], 1'b1);
    if (CS == 1) applyStimulus(~(c[23:16] + c[15:8] + c[7:0]), 1'b1);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int rbase, fbase, cbase, dbase;
    rst_n   = 1'b0;
    RX      = 1'b1;
    trmt    = 1'b0;
    tx_data = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", {31'd0, TX}, 32'd1);
    checkOutput("reset_cmd", {8'd0, cmd}, 32'd0);
    checkOutput("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("reset_cmd_err", {31'd0, cmd_err}, 32'd0);
    checkOutput("reset_frm_err", {31'd0, frm_err}, 32'd0);
    checkOutput("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset_tx_done", {31'd0, tx_done}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] basic command receive");
    rbase = rdy_count;
    fbase = frm_count;
    send_cmd(24'h123456);
    repeat (4) @(negedge clk);
    checkOutput("rx_cmd_basic", {8'd0, cmd}, 32'h123456);
    checkOutput("rx_rdy_basic", rdy_count - rbase, 1);
    checkOutput("rx_frm_basic", frm_count - fbase, 0);

    $display("[TB] basic response transmit");
    applyTx(16'hABCD, 1'b0);

    $display("[TB] inter-byte timeout");
    rbase = rdy_count;
    applyStimulus(8'h12, 1'b1);
    repeat (200) @(negedge clk);
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hBB, 1'b1);
    checkOutput("timeout_no_early_rdy", rdy_count - rbase, 0);
    applyStimulus(8'hCC, 1'b1);
    if (CS == 1) applyStimulus(8'hCE, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("timeout_cmd", {8'd0, cmd}, 32'hAABBCC);
    checkOutput("timeout_rdy", rdy_count - rbase, 1);

    $display("[TB] framing error resync");
    rbase = rdy_count;
    fbase = frm_count;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b0);
    checkOutput("frm_err_pulse", frm_count - fbase, 1);
    send_cmd(24'h010203);
    repeat (4) @(negedge clk);
    checkOutput("frm_cmd_after", {8'd0, cmd}, 32'h010203);
    checkOutput("frm_rdy_after", rdy_count - rbase, 1);

    $display("[TB] trmt while busy");
    applyTx(16'hABCD, 1'b1);

`ifdef SERIAL_COMM_PKT_CHECKSUM_EN
    $display("[TB] checksum receive");
    rbase = rdy_count;
    cbase = cerr_count;
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'hF9, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("cs_good_cmd", {8'd0, cmd}, 32'h010203);
    checkOutput("cs_good_rdy", rdy_count - rbase, 1);
    checkOutput("cs_good_err", cerr_count - cbase, 0);
    rbase = rdy_count;
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("cs_bad_err", cerr_count - cbase, 1);
    checkOutput("cs_bad_rdy", rdy_count - rbase, 0);
    checkOutput("cs_bad_cmd", {8'd0, cmd}, 32'h010203);
`else
    cbase = 0;
    checkOutput("cmd_err_never", cerr_count - cbase, 0);
`endif

    $display("[TB] reset during response");
    dbase = done_count;
    @(negedge clk);
    tx_data = 16'hABCD;
    trmt    = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("midrst_busy_before", {31'd0, tx_busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_tx", {31'd0, TX}, 32'd1);
    checkOutput("midrst_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("midrst_cmd", {8'd0, cmd}, 32'd0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("midrst_no_done", done_count - dbase, 0);
    checkOutput("midrst_tx_idle", {31'd0, TX}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
